// File: rtl/apb_mem_ctrl.sv
// apb_mem_ctrl
//   APB slave that bridges single-word transfers onto a synchronous SRAM-style
//   memory port. Every transfer runs through a small FSM:
//     IDLE -> [WAIT] -> MEM -> [RD_CAP] -> RESP -> IDLE
//   Byte addresses whose two low bits are non-zero are answered in RESP with
//   pslverr=1 and never reach the memory.
//
// Parameters
//   DATA_W      APB / memory data width
//   ADDR_W      memory word-address width (2^ADDR_W words)
//   WAIT_CYCLES extra wait states before each memory access (0..15)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   psel, penable       APB select / access-phase enable
//   pwrite, paddr       direction (1 = write), byte address
//   pwdata, prdata      write data in, read data out
//   pready, pslverr     registered completion pulse and error flag
//   mem_ce/wren/rden    one-cycle memory strobes, asserted only in MEM
//   mem_addr            memory word address (latched paddr[ADDR_W+1:2])
//   mem_wr_data         memory write data (latched pwdata)
//   mem_rd_data         memory read data, valid the cycle after a read strobe
module apb_mem_ctrl #(
  parameter int DATA_W      = 21,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W+1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              mem_ce,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_MEM,
    ST_RD_CAP,
    ST_RESP
  } state_t;

  // Counter is loaded with WAIT_CYCLES-1 so that WAIT lasts exactly
  // WAIT_CYCLES cycles; the load value is only used when WAIT_CYCLES > 0.
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t              state;
  logic [3:0]          wait_cnt;
  logic [ADDR_W+1:0]   addr_q;
  logic                write_q;
  logic [DATA_W-1:0]   wdata_q;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

  // Address and write data come straight from the latch, so they are stable
  // from the moment the transfer is accepted until it completes.
  assign mem_addr    = addr_q[ADDR_W+1:2];
  assign mem_wr_data = wdata_q;

  // Latched request fields are pure data and are not reset.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && psel && !penable) begin
      addr_q  <= paddr;
      write_q <= pwrite;
      wdata_q <= pwdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      mem_ce   <= 1'b0;
      mem_wren <= 1'b0;
      mem_rden <= 1'b0;
    end else begin
      // Strobes and the response are single-cycle pulses.
      mem_ce   <= 1'b0;
      mem_wren <= 1'b0;
      mem_rden <= 1'b0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;

      case (state)
        ST_IDLE: begin
          // Only a setup phase (penable low) starts a transfer.
          if (psel && !penable) begin
            if (WAIT_CYCLES > 0) begin
              state    <= ST_WAIT;
              wait_cnt <= WAIT_LOAD;
            end else if (misaligned(paddr[1:0])) begin
              state   <= ST_RESP;
              pready  <= 1'b1;
              pslverr <= 1'b1;
            end else begin
              state    <= ST_MEM;
              mem_ce   <= 1'b1;
              mem_wren <= pwrite;
              mem_rden <= !pwrite;
            end
          end
        end

        ST_WAIT: begin
          if (!psel) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
          end else if (wait_cnt == 4'd0) begin
            if (misaligned(addr_q[1:0])) begin
              state   <= ST_RESP;
              pready  <= 1'b1;
              pslverr <= 1'b1;
            end else begin
              state    <= ST_MEM;
              mem_ce   <= 1'b1;
              mem_wren <= write_q;
              mem_rden <= !write_q;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        ST_MEM: begin
          // An abort here still leaves a write committed to memory.
          if (!psel) begin
            state <= ST_IDLE;
          end else if (write_q) begin
            state  <= ST_RESP;
            pready <= 1'b1;
          end else begin
            state <= ST_RD_CAP;
          end
        end

        ST_RD_CAP: begin
          if (!psel) begin
            state <= ST_IDLE;
          end else begin
            prdata <= mem_rd_data;
            state  <= ST_RESP;
            pready <= 1'b1;
          end
        end

        ST_RESP: begin
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// Bench for apb_mem_ctrl: two instances (no wait states and three wait
// states) share one APB master; use3 routes psel to the second instance and
// selects its outputs. Each instance has its own behavioural memory.
module tb_apb_mem_ctrl;

  localparam int DW = 21;
  localparam int AW = 8;

  logic          clk;
  logic          rst;
  logic          use3;
  logic          psel, penable, pwrite;
  logic [AW+1:0] paddr;
  logic [DW-1:0] pwdata;

  logic          psel0, psel3;
  logic [DW-1:0] prdata0, prdata3, mem_wr_data0, mem_wr_data3, mem_rd_data0, mem_rd_data3;
  logic          pready0, pready3, pslverr0, pslverr3;
  logic          mem_ce0, mem_ce3, mem_wren0, mem_wren3, mem_rden0, mem_rden3;
  logic [AW-1:0] mem_addr0, mem_addr3;

  assign psel0 = psel & ~use3;
  assign psel3 = psel & use3;

  apb_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .mem_ce(mem_ce0), .mem_wren(mem_wren0),
    .mem_rden(mem_rden0), .mem_addr(mem_addr0), .mem_wr_data(mem_wr_data0),
    .mem_rd_data(mem_rd_data0)
  );

  apb_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .psel(psel3), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3),
    .pslverr(pslverr3), .mem_ce(mem_ce3), .mem_wren(mem_wren3),
    .mem_rden(mem_rden3), .mem_addr(mem_addr3), .mem_wr_data(mem_wr_data3),
    .mem_rd_data(mem_rd_data3)
  );

  // Selected-instance view of the outputs
  logic [DW-1:0] prdata_m, mem_wr_data_m;
  logic [AW-1:0] mem_addr_m;
  logic          pready_m, pslverr_m, mem_ce_m, mem_wren_m, mem_rden_m;
  assign prdata_m      = use3 ? prdata3      : prdata0;
  assign pready_m      = use3 ? pready3      : pready0;
  assign pslverr_m     = use3 ? pslverr3     : pslverr0;
  assign mem_ce_m      = use3 ? mem_ce3      : mem_ce0;
  assign mem_wren_m    = use3 ? mem_wren3    : mem_wren0;
  assign mem_rden_m    = use3 ? mem_rden3    : mem_rden0;
  assign mem_addr_m    = use3 ? mem_addr3    : mem_addr0;
  assign mem_wr_data_m = use3 ? mem_wr_data3 : mem_wr_data0;

  // Synchronous memories: read data appears the cycle after the strobe.
  logic [DW-1:0] mem0 [256];
  logic [DW-1:0] mem3 [256];
  always @(posedge clk) begin
    if (mem_ce0 && mem_wren0) mem0[mem_addr0] <= mem_wr_data0;
    if (mem_ce0 && mem_rden0) mem_rd_data0 <= mem0[mem_addr0];
  end
  always @(posedge clk) begin
    if (mem_ce3 && mem_wren3) mem3[mem_addr3] <= mem_wr_data3;
    if (mem_ce3 && mem_rden3) mem_rd_data3 <= mem3[mem_addr3];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic          wr;
    logic          err;
    logic [DW-1:0] rd;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          wr;
    logic [AW+1:0] addr;
    logic [DW-1:0] wd;
    logic          err;
    logic [DW-1:0] rd;
    int            lat;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  // One APB transfer on the selected instance. Called #1 after a rising edge;
  // returns #1 after the edge that closes the RESP cycle, bus idle, so the
  // next call places its setup phase in the cycle right after RESP.
  task automatic xfer(input logic wr, input logic [AW+1:0] addr, input logic [DW-1:0] wd,
                      input logic err, input logic [DW-1:0] rd, input int lat, input string tag);
    int   cyc, nstb, stb_cyc, wait_n;
    logic done;
    exp_t e;
    wait_n = use3 ? 3 : 0;
    sb.push_back('{wr: wr, err: err, rd: rd});
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    cyc = 0; nstb = 0; stb_cyc = -1; done = 1'b0;
    while (!done && cyc < 40) begin
      @(posedge clk); #1;
      penable = 1'b1;
      cyc++;
      if (mem_ce_m) begin
        nstb++;
        stb_cyc = cyc;
        chk({tag, " mem_addr"}, 32'(mem_addr_m), 32'(addr[AW+1:2]));
        chk({tag, " mem_wren"}, 32'(mem_wren_m), 32'(wr));
        chk({tag, " mem_rden"}, 32'(mem_rden_m), 32'(!wr));
        if (wr) chk({tag, " mem_wr_data"}, 32'(mem_wr_data_m), 32'(wd));
      end
      if (!pready_m) chk({tag, " pslverr_without_pready"}, 32'(pslverr_m), 32'd0);
      if (pready_m) begin
        done = 1'b1;
        e = sb.pop_front();
        chk({tag, " pslverr"}, 32'(pslverr_m), 32'(e.err));
        if (!e.wr) chk({tag, " prdata"}, 32'(prdata_m), 32'(e.rd));
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: no pready after %0d cycles", tag, cyc);
      void'(sb.pop_front());
    end
    chk({tag, " latency"}, 32'(cyc), 32'(lat));
    chk({tag, " strobes"}, 32'(nstb), err ? 32'd0 : 32'd1);
    if (!err) chk({tag, " strobe_cycle"}, 32'(stb_cyc), 32'(1 + wait_n));
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nstb, nrdy;
    //            wr    addr      wdata       err   rdata       lat
    vecs[0]  = '{1'b1, 10'h014, 21'h1ABCD, 1'b0, 21'h00000, 2};
    vecs[1]  = '{1'b0, 10'h014, 21'h00000, 1'b0, 21'h1ABCD, 3};
    vecs[2]  = '{1'b1, 10'h016, 21'h00777, 1'b1, 21'h00000, 1};
    vecs[3]  = '{1'b0, 10'h014, 21'h00000, 1'b0, 21'h1ABCD, 3};
    vecs[4]  = '{1'b1, 10'h3FC, 21'h15555, 1'b0, 21'h00000, 2};
    vecs[5]  = '{1'b0, 10'h3FC, 21'h00000, 1'b0, 21'h15555, 3};
    vecs[6]  = '{1'b1, 10'h000, 21'h00001, 1'b0, 21'h00000, 2};
    vecs[7]  = '{1'b0, 10'h000, 21'h00000, 1'b0, 21'h00001, 3};
    vecs[8]  = '{1'b0, 10'h001, 21'h00000, 1'b1, 21'h00001, 1};
    vecs[9]  = '{1'b1, 10'h008, 21'h1FFFFF, 1'b0, 21'h00000, 2};
    vecs[10] = '{1'b0, 10'h008, 21'h00000, 1'b0, 21'h1FFFFF, 3};
    vecs[11] = '{1'b0, 10'h3FE, 21'h00000, 1'b1, 21'h1FFFFF, 1};

    rst = 1'b1; use3 = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset pready0", 32'(pready0), 32'd0);
    chk("reset pslverr0", 32'(pslverr0), 32'd0);
    chk("reset prdata0", 32'(prdata0), 32'd0);
    chk("reset mem_ce0", 32'(mem_ce0), 32'd0);
    chk("reset pready3", 32'(pready3), 32'd0);
    chk("reset prdata3", 32'(prdata3), 32'd0);

    // Access-phase pattern while idle must not start a transfer.
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 10'h014; pwdata = 21'h0DEAD;
    nstb = 0; nrdy = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (mem_ce0) nstb++;
      if (pready0) nrdy++;
    end
    chk("idle_penable strobes", 32'(nstb), 32'd0);
    chk("idle_penable pready", 32'(nrdy), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    // Table-driven transfers, back-to-back, no wait states.
    for (int i = 0; i < 12; i++)
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].err, vecs[i].rd, vecs[i].lat,
           $sformatf("vec%0d", i));

    // Reset while the read is in RD_CAP: dropped, no response, prdata cleared.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 10'h014;
    @(posedge clk); #1 penable = 1'b1;          // MEM
    @(posedge clk); #1 rst = 1'b1;              // RD_CAP
    @(posedge clk); #1 rst = 1'b0;
    chk("rdcap_reset pready", 32'(pready0), 32'd0);
    chk("rdcap_reset prdata", 32'(prdata0), 32'd0);
    chk("rdcap_reset pslverr", 32'(pslverr0), 32'd0);
    nstb = 0; nrdy = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (mem_ce0 || mem_wren0 || mem_rden0) nstb++;
      if (pready0) nrdy++;
    end
    chk("rdcap_reset strobes", 32'(nstb), 32'd0);
    chk("rdcap_reset late_pready", 32'(nrdy), 32'd0);
    psel = 1'b0; penable = 1'b0;
    @(posedge clk); #1;

    // Memory survives the reset.
    xfer(1'b0, 10'h014, 21'h0, 1'b0, 21'h1ABCD, 3, "post_reset_rd");

    // Three wait states.
    use3 = 1'b1;
    xfer(1'b1, 10'h3FC, 21'h0ABCD, 1'b0, 21'h0, 5, "w3_wr");
    xfer(1'b0, 10'h3FC, 21'h0, 1'b0, 21'h0ABCD, 6, "w3_rd");
    xfer(1'b1, 10'h016, 21'h00123, 1'b1, 21'h0, 4, "w3_misaligned");

    // Master abort during WAIT.
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h020; pwdata = 21'h12345;
    @(posedge clk); #1;                          // WAIT
    psel = 1'b0; penable = 1'b0;
    nstb = 0; nrdy = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (mem_ce3 || mem_wren3 || mem_rden3) nstb++;
      if (pready3) nrdy++;
    end
    chk("wait_abort strobes", 32'(nstb), 32'd0);
    chk("wait_abort pready", 32'(nrdy), 32'd0);

    xfer(1'b0, 10'h3FC, 21'h0, 1'b0, 21'h0ABCD, 6, "w3_after_abort");
    use3 = 1'b0;

    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
